// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared encodings and defaults for the fetch PC stage.
// Rev    : 1.0
// ============================================================================
package fetch_pkg;

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] PEND = 2'd2;

    typedef enum logic [1:0] {
        S_BOOT = BOOT,
        S_RUN  = RUN,
        S_PEND = PEND
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int          DEFAULT_INSTR_BYTES  = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_stat_counter.sv
`default_nettype none
// ============================================================================
// Module : fetch_stat_counter
// Brief  : Saturating event counter, cleared by asynchronous reset.
// Rev    : 1.0
// ============================================================================
module fetch_stat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module : fetch_pc_unit
// Brief  : PC register and fetch-request handshake with branch redirect and
//          buffered redirect under memory back-pressure.
//          Optional statistics counters: define FETCH_PC_STATS_EN.
// Rev    : 1.0
// ============================================================================
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int                  INSTR_BYTES  = DEFAULT_INSTR_BYTES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                take_branch_target,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                fetch_ready,
    output logic                fetch_valid,
    output logic [PC_WIDTH-1:0] fetch_pc,
    output logic [PC_WIDTH-1:0] fetch_pc_plus,
    output logic                fetch_squash,
    output logic                flush_ifid
`ifdef FETCH_PC_STATS_EN
    ,
    output logic [15:0]         redirect_count,
    output logic [15:0]         backpressure_count
`endif
);

    fetch_state_t        r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_pend_target;
    logic                r_fetch_valid;
    logic                r_flush_ifid;

    logic                w_accept;
    logic                w_redirect;
    logic [PC_WIDTH-1:0] w_pc_plus;

    assign w_accept   = r_fetch_valid && fetch_ready;
    // Branches are only honoured in RUN and outside a stall; decode re-presents them otherwise.
    assign w_redirect = (r_state == S_RUN) && !stall && take_branch_target;
    assign w_pc_plus  = r_pc + PC_WIDTH'(INSTR_BYTES);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_VECTOR;
            r_pend_target <= '0;
            r_fetch_valid <= 1'b0;
            r_flush_ifid  <= 1'b0;
        end else begin
            r_flush_ifid <= 1'b0;
            case (r_state)
                S_BOOT: begin
                    r_state       <= S_RUN;
                    r_fetch_valid <= 1'b1;
                end
                S_RUN: begin
                    if (!stall) begin
                        if (take_branch_target) begin
                            r_flush_ifid <= 1'b1;
                            if (w_accept) begin
                                r_pc <= branch_target;
                            end else begin
                                r_pend_target <= branch_target;
                                r_state       <= S_PEND;
                            end
                        end else if (w_accept) begin
                            r_pc <= w_pc_plus;
                        end
                    end
                end
                S_PEND: begin
                    if (!stall && w_accept) begin
                        r_pc    <= r_pend_target;
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state       <= S_BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    // Any acceptance in PEND is the stale pre-redirect address.
    assign fetch_squash  = w_accept && (w_redirect || (r_state == S_PEND));
    assign fetch_valid   = r_fetch_valid;
    assign fetch_pc      = r_pc;
    assign fetch_pc_plus = w_pc_plus;
    assign flush_ifid    = r_flush_ifid;

`ifdef FETCH_PC_STATS_EN
    fetch_stat_counter #(.WIDTH(16)) u_redirect_cnt (
        .clk     (clock),
        .rst     (reset),
        .i_inc   (w_redirect),
        .o_count (redirect_count)
    );

    fetch_stat_counter #(.WIDTH(16)) u_backpressure_cnt (
        .clk     (clock),
        .rst     (reset),
        .i_inc   (r_fetch_valid && !fetch_ready),
        .o_count (backpressure_count)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_pc_unit
// Brief  : Directed table-driven bench for fetch_pc_unit.
// Rev    : 1.0
// ============================================================================
module tb_fetch_pc_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        take_branch_target;
    logic [31:0] branch_target;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_plus;
    logic        fetch_squash;
    logic        flush_ifid;
`ifdef FETCH_PC_STATS_EN
    logic [15:0] redirect_count;
    logic [15:0] backpressure_count;
`endif

    int n_tests;
    int n_fail;

    fetch_pc_unit dut (
        .clock              (clock),
        .reset              (reset),
        .stall              (stall),
        .take_branch_target (take_branch_target),
        .branch_target      (branch_target),
        .fetch_ready        (fetch_ready),
        .fetch_valid        (fetch_valid),
        .fetch_pc           (fetch_pc),
        .fetch_pc_plus      (fetch_pc_plus),
        .fetch_squash       (fetch_squash),
        .flush_ifid         (flush_ifid)
`ifdef FETCH_PC_STATS_EN
        ,
        .redirect_count     (redirect_count),
        .backpressure_count (backpressure_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        stall;
        logic        take;
        logic [31:0] tgt;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic        esq;
        logic        efl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic tk, input logic [31:0] tg,
                                input logic rd, input logic ev, input logic [31:0] pc,
                                input logic sq, input logic fl);
        vec_t v;
        v.stall = st; v.take = tk; v.tgt = tg; v.rdy = rd;
        v.ev = ev; v.epc = pc; v.esq = sq; v.efl = fl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [31:0] pc,
                              input logic sq, input logic fl);
        check({tag, " valid"},   {31'd0, fetch_valid},  {31'd0, ev});
        check({tag, " pc"},      fetch_pc,              pc);
        check({tag, " pc_plus"}, fetch_pc_plus,         pc + 32'd4);
        check({tag, " squash"},  {31'd0, fetch_squash}, {31'd0, sq});
        check({tag, " flush"},   {31'd0, flush_ifid},   {31'd0, fl});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1; stall = 1'b0; take_branch_target = 1'b0;
        branch_target = 32'h0; fetch_ready = 1'b1;

        //           stall tk  target        rdy v  pc            sq  fl
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0000_0000, 0, 0)); // BOOT
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_0000, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_0004, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_0008, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_000C, 0, 0));
        vecs.push_back(mk(0, 1, 32'h200,      0, 1, 32'h0000_0010, 0, 0)); // buffered redirect
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0000_0010, 0, 1));
        vecs.push_back(mk(0, 1, 32'h999,      0, 1, 32'h0000_0010, 0, 0)); // ignored in PEND
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_0010, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_0200, 0, 0));
        vecs.push_back(mk(0, 1, 32'h8,        1, 1, 32'h0000_0204, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0000_0008, 0, 1));
        vecs.push_back(mk(0, 1, 32'h100,      1, 1, 32'h0000_0008, 1, 0)); // accepted redirect
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_0100, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_0104, 0, 0));
        vecs.push_back(mk(0, 1, 32'h20,       1, 1, 32'h0000_0108, 1, 0));
        vecs.push_back(mk(1, 1, 32'h500,      1, 1, 32'h0000_0020, 0, 1)); // stall window
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 32'h0000_0020, 0, 0));
        vecs.push_back(mk(1, 1, 32'h600,      1, 1, 32'h0000_0020, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 32'h0000_0020, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_0020, 0, 0));
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFC,1, 1, 32'h0000_0024, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 0, 1)); // pc_plus wraps
        vecs.push_back(mk(0, 1, 32'h40,       1, 1, 32'h0000_0000, 1, 0));
        vecs.push_back(mk(0, 1, 32'h300,      0, 1, 32'h0000_0040, 0, 1));
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 32'h0000_0040, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0000_0040, 0, 0));

        repeat (2) @(negedge clock);
        #1 check_outs("in_reset", 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            stall              = vecs[i].stall;
            take_branch_target = vecs[i].take;
            branch_target      = vecs[i].tgt;
            fetch_ready        = vecs[i].rdy;
            #1 check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc,
                          vecs[i].esq, vecs[i].efl);
            @(negedge clock);
        end

        // Asynchronous reset while a redirect to 0x300 is buffered.
        stall = 1'b0; take_branch_target = 1'b0; fetch_ready = 1'b1;
        reset = 1'b1;
        #1 check_outs("pend_reset", 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1 check_outs("post_reset_boot", 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        #1 check_outs("post_reset_first", 1'b1, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        #1 check_outs("post_reset_second", 1'b1, 32'h4, 1'b0, 1'b0);

`ifdef FETCH_PC_STATS_EN
        fetch_ready = 1'b0;
        repeat (5) @(negedge clock);
        fetch_ready = 1'b1; take_branch_target = 1'b1; branch_target = 32'h80;
        @(negedge clock);
        branch_target = 32'h90;
        @(negedge clock);
        take_branch_target = 1'b0;
        #1;
        check("redirect_count", {16'd0, redirect_count}, 32'd2);
        check("backpressure_count", {16'd0, backpressure_count}, 32'd5);
        fetch_ready = 1'b0;
        repeat (70000) @(negedge clock);
        #1 check("backpressure_sat", {16'd0, backpressure_count}, 32'h0000_FFFF);
        check("redirect_hold", {16'd0, redirect_count}, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and fetch-request stage of the pipeline; it sits in front of the IF/ID register.
- Consumes take_branch_target and the branch target from decode-stage branch resolution.
- Issues instruction-memory fetch requests with a valid/ready handshake.
- Redirects the PC on taken branches, squashes the wrong-path fetch and buffers a redirect that arrives while memory back-pressures.

Parameters:
- PC_WIDTH, 32, width of PC and target.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- INSTR_BYTES, 4, PC increment per sequential fetch.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard-unit freeze of fetch and decode.
- take_branch_target  input  1  decode resolved a taken branch or jump this cycle.
- branch_target  input  PC_WIDTH  redirect address; valid when take_branch_target=1.
- fetch_ready  input  1  instruction memory accepts the request this cycle.
- fetch_valid  output  1  fetch request valid.
- fetch_pc  output  PC_WIDTH  fetch address.
- fetch_pc_plus  output  PC_WIDTH  fetch_pc+INSTR_BYTES, forwarded for link values.
- fetch_squash  output  1  the fetch accepted this cycle is wrong-path.
- flush_ifid  output  1  one-cycle pulse that clears IF/ID.

Behaviour:
- Reset (asynchronous, any state): pc=RESET_VECTOR, state=BOOT, fetch_valid=0, fetch_squash=0, flush_ifid=0, pend_target=0.
- States:
  - BOOT: one cycle, no request; next state RUN.
  - RUN: issuing sequential fetches.
  - PEND: a redirect is captured while a request is outstanding.
- Outputs by state:
  - fetch_valid=1 in RUN and PEND.
  - fetch_pc=pc.
  - fetch_pc_plus=pc+INSTR_BYTES, truncated to PC_WIDTH (wraps modulo 2^PC_WIDTH).
- Handshake rules:
  - Acceptance happens when fetch_valid && fetch_ready.
  - fetch_pc must hold stable while fetch_valid && !fetch_ready.
  - fetch_valid never drops in RUN or PEND without acceptance, except on reset.
- Stall:
  - stall=1 freezes pc and state.
  - take_branch_target is ignored during stall, because decode re-presents the branch after release.
  - Memory acceptance during stall is still allowed; pc is not advanced, so the same address is re-requested.
- RUN, no stall:
  - accept && take_branch_target: pc<=branch_target, fetch_squash=1 this cycle, flush_ifid=1 next cycle.
  - accept && !take_branch_target: pc<=pc+INSTR_BYTES.
  - !accept && take_branch_target: pend_target<=branch_target, state<=PEND, flush_ifid=1 next cycle.
  - !accept && !take_branch_target: hold.
- PEND:
  - Keep presenting the old pc.
  - On accept: fetch_squash=1, pc<=pend_target, state<=RUN.
  - take_branch_target is ignored in PEND, because decode holds a flushed instruction.
  - stall in PEND holds state and pend_target.
- flush_ifid: registered, exactly one cycle high per redirect; it never asserts twice for one redirect.
- Latency:
  - Branch-to-target-request is 1 cycle when memory is ready.
  - Target request is 1 cycle after acceptance of the outstanding request when in PEND.
- Reset mid-PEND discards pend_target; there is no fetch after reset until BOOT completes.

Optional Feature:
- Macro: FETCH_PC_STATS_EN.
- Defined:
  - Adds output redirect_count [15:0], incremented on every redirect capture (RUN taken branch, accepted or buffered).
  - Adds output backpressure_count [15:0], incremented each cycle fetch_valid && !fetch_ready.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - state encoding localparams: BOOT=2'd0, RUN=2'd1, PEND=2'd2;
  - default RESET_VECTOR;
  - INSTR_BYTES.
- Optional sub-module fetch_stat_counter: saturating 16-bit counter, used twice under FETCH_PC_STATS_EN.
- Core logic stays in one module.

Test Plan:
- Reset release, fetch_ready=1:
  - cycle 0: fetch_valid=0;
  - then fetch_pc sequence 0x0, 0x4, 0x8, 0xC;
  - flush_ifid stays 0.
- At pc=0x8, take_branch_target=1 with branch_target=0x100 and fetch_ready=1:
  - fetch_squash=1 that cycle;
  - next cycle fetch_pc=0x100 and flush_ifid=1 for one cycle only.
- At pc=0x10, fetch_ready=0 and take_branch_target=1 with target 0x200; hold fetch_ready low 3 cycles, then raise it:
  - fetch_pc stays 0x10 throughout the wait;
  - flush_ifid pulses once;
  - acceptance cycle has fetch_squash=1;
  - next fetch_pc=0x200.
- stall=1 for 4 cycles at pc=0x20 with take_branch_target toggling:
  - pc stays 0x20;
  - no flush;
  - after release, sequential to 0x24.
- Assert reset in PEND with pend_target=0x300:
  - outputs return to reset values immediately;
  - after release, the first fetch is RESET_VECTOR, not 0x300.
- With FETCH_PC_STATS_EN defined:
  - two redirects and 5 backpressure cycles give redirect_count=2 and backpressure_count=5;
  - forcing 70000 backpressure cycles gives backpressure_count=16'hFFFF.
